// File: rtl/mm_timer_slave.sv
// Memory-mapped prescaled timer slave: compare match, one-shot/auto-reload, sticky match flag, irq.
// Optional PWM output and DUTY register (offset 5) when TIMER_PWM_EN is defined.
module mm_timer_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [31:0]           address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
`ifdef TIMER_PWM_EN
  output logic                  pwm_out,
`endif
  output logic                  irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
`ifdef TIMER_PWM_EN
  localparam logic [2:0] OFF_DUTY   = 3'd5;
`endif

  state_t                  state_q, state_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [PRESC_WIDTH-1:0]  presc_q, presc_d;
  logic [PRESC_WIDTH-1:0]  pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0]   compare_q, compare_d;
  logic [DATA_WIDTH-1:0]   count_q, count_d;
  logic                    match_q, match_d;
  logic                    irq_q, irq_d;
`ifdef TIMER_PWM_EN
  logic [DATA_WIDTH-1:0]   duty_q, duty_d;
  logic                    pwm_q, pwm_d;
`endif

  logic [2:0] offset;
  logic       tick;
  logic       match_set;
  logic       unused_addr_bits;

  assign offset           = address[4:2];
  assign unused_addr_bits = ^{address[31:5], address[1:0]};

  // Next-state: timer evolution first, then CPU writes override where they collide.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    compare_d = compare_q;
    count_d   = count_q;
    tick      = 1'b0;
    match_set = 1'b0;
`ifdef TIMER_PWM_EN
    duty_d    = duty_q;
`endif

    if (state_q == ST_RUN) begin
      if (pcnt_q == presc_q) begin
        pcnt_d = '0;
        tick   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        if (ctrl_q[1]) begin
          count_d = '0;
        end else begin
          state_d   = ST_DONE;
          ctrl_d[0] = 1'b0;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (we) begin
      case (offset)
        OFF_CTRL: begin
          ctrl_d = wd[2:0];
          if (wd[0]) begin
            state_d = ST_RUN;
            if (state_q == ST_DONE) begin
              count_d = '0;
              pcnt_d  = '0;
            end
          end else begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
          end
        end
        OFF_PRESC: presc_d   = wd[PRESC_WIDTH-1:0];
        OFF_CMP:   compare_d = wd;
        OFF_COUNT: count_d   = wd;
`ifdef TIMER_PWM_EN
        OFF_DUTY:  duty_d    = wd;
`endif
        default: ;
      endcase
    end

    // A match set in the same cycle as a write-1-to-clear keeps the flag set.
    match_d = (match_q & ~(we && (offset == OFF_STATUS) && wd[0])) | match_set;
    irq_d   = match_q & ctrl_q[2];
`ifdef TIMER_PWM_EN
    pwm_d   = (state_q == ST_RUN) && (count_q < duty_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      compare_q <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
`ifdef TIMER_PWM_EN
      duty_q    <= '0;
      pwm_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      compare_q <= compare_d;
      count_q   <= count_d;
      match_q   <= match_d;
      irq_q     <= irq_d;
`ifdef TIMER_PWM_EN
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
`endif
    end
  end

  // Zero-latency read path; a simultaneous write is not visible until the next cycle.
  always_comb begin
    rd = '0;
    if (re) begin
      case (offset)
        OFF_CTRL:   rd[2:0]             = ctrl_q;
        OFF_PRESC:  rd[PRESC_WIDTH-1:0] = presc_q;
        OFF_CMP:    rd                  = compare_q;
        OFF_COUNT:  rd                  = count_q;
        OFF_STATUS: rd[2:0]             = {state_q, match_q};
`ifdef TIMER_PWM_EN
        OFF_DUTY:   rd                  = duty_q;
`endif
        default:    rd                  = '0;
      endcase
    end
  end

  assign irq = irq_q;
`ifdef TIMER_PWM_EN
  assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_mm_timer_slave.sv
// Directed self-checking bench for mm_timer_slave (PWM section active when TIMER_PWM_EN is defined).
module tb_mm_timer_slave;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_PRESC  = 32'h04;
  localparam logic [31:0] A_CMP    = 32'h08;
  localparam logic [31:0] A_COUNT  = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_OFF5   = 32'h14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] address = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rd;
  logic        irq;
`ifdef TIMER_PWM_EN
  logic        pwm_out;
  int          highs;
`endif

  int total = 0;
  int bad   = 0;

  mm_timer_slave #(.DATA_WIDTH(32), .PRESC_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wd      (wd),
    .address (address),
    .we      (we),
    .re      (re),
    .rd      (rd),
`ifdef TIMER_PWM_EN
    .pwm_out (pwm_out),
`endif
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address = a; wd = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    address = a; re = 1'b1;
    #1;
    chk(tag, rd, exp);
    re = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset: writes during reset must not take effect.
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      address = 32'(i) << 2; wd = 32'hFFFF_FFFF; we = 1'b1;
      @(posedge clk);
      #1;
    end
    we = 1'b0;
    for (int i = 0; i < 5; i++) rd_chk($sformatf("rst_reg%0d", i), 32'(i) << 2, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    step(1);
    rst_n = 1'b1;
    rd_chk("off6", 32'h18, 32'h0);
    rd_chk("off7", 32'h1C, 32'h0);
    step(1);

    // Read-while-write returns the old value; new value the next cycle.
    bus_write(A_CMP, 32'hAA);
    address = A_CMP; wd = 32'h55; we = 1'b1; re = 1'b1;
    #1;
    chk("rw_old", rd, 32'hAA);
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("rw_new", rd, 32'h55);
    re = 1'b0;
    #1;
    chk("rd_idle", rd, 32'h0);
`ifndef TIMER_PWM_EN
    bus_write(A_OFF5, 32'h1234);
    rd_chk("off5_nopwm", A_OFF5, 32'h0);
`endif

    // Auto-reload: PRESCALE=2, COMPARE=3, CTRL=7; CTRL commit edge = E0.
    reset_dut();
    bus_write(A_PRESC, 32'd2);
    bus_write(A_CMP, 32'd3);
    bus_write(A_CTRL, 32'h7);
    rd_chk("ar_c0", A_COUNT, 32'd0);
    step(2);  rd_chk("ar_e2", A_COUNT, 32'd0);
    step(1);  rd_chk("ar_e3", A_COUNT, 32'd1);
    step(3);  rd_chk("ar_e6", A_COUNT, 32'd2);
    step(3);  rd_chk("ar_e9", A_COUNT, 32'd3);
    step(2);  rd_chk("ar_e11_st", A_STATUS, 32'h2);
    step(1);  rd_chk("ar_e12_cnt", A_COUNT, 32'd0);
    rd_chk("ar_e12_st", A_STATUS, 32'h3);
    chk("ar_e12_irq", {31'b0, irq}, 32'h0);
    step(1);  chk("ar_e13_irq", {31'b0, irq}, 32'h1);
    bus_write(A_STATUS, 32'h1);
    rd_chk("ar_e14_st", A_STATUS, 32'h2);
    chk("ar_e14_irq", {31'b0, irq}, 32'h1);
    step(1);  chk("ar_e15_irq", {31'b0, irq}, 32'h0);
    step(8);  rd_chk("ar_e23_st", A_STATUS, 32'h2);
    step(1);  rd_chk("ar_e24_st", A_STATUS, 32'h3);
    step(1);  chk("ar_e25_irq", {31'b0, irq}, 32'h1);
    // Asynchronous reset mid-count clears everything at once.
    rst_n = 1'b0;
    #1;
    chk("async_irq", {31'b0, irq}, 32'h0);
    rd_chk("async_cnt", A_COUNT, 32'h0);
    rd_chk("async_st", A_STATUS, 32'h0);
    step(1);
    rst_n = 1'b1;

    // One-shot: PRESCALE=0, COMPARE=5, CTRL=1.
    bus_write(A_CMP, 32'd5);
    bus_write(A_CTRL, 32'h1);
    step(5);  rd_chk("os_e5_cnt", A_COUNT, 32'd5);
    rd_chk("os_e5_st", A_STATUS, 32'h2);
    step(1);  rd_chk("os_e6_cnt", A_COUNT, 32'd5);
    rd_chk("os_e6_ctrl", A_CTRL, 32'h0);
    rd_chk("os_e6_st", A_STATUS, 32'h5);
    step(2);  rd_chk("os_hold", A_COUNT, 32'd5);
    chk("os_irq", {31'b0, irq}, 32'h0);
    bus_write(A_CTRL, 32'h1);
    rd_chk("os_re_cnt", A_COUNT, 32'd0);
    rd_chk("os_re_st", A_STATUS, 32'h3);

    // Simultaneous events: PRESCALE=0, COMPARE=0x12, auto-reload, irq enabled.
    reset_dut();
    bus_write(A_CMP, 32'h12);
    bus_write(A_CTRL, 32'h7);
    bus_write(A_COUNT, 32'h10);          // edge E, also a tick
    rd_chk("sim_a_cnt", A_COUNT, 32'h10);
    step(2);                             // E+2, count 0x12
    rd_chk("sim_pre", A_COUNT, 32'h12);
    bus_write(A_STATUS, 32'h1);          // E+3: match edge
    rd_chk("sim_b_st", A_STATUS, 32'h3);
    rd_chk("sim_b_cnt", A_COUNT, 32'h0);
    chk("sim_b_irq", {31'b0, irq}, 32'h0);
    bus_write(A_STATUS, 32'h1);          // E+4: no match
    rd_chk("sim_c_st", A_STATUS, 32'h2);
    chk("sim_c_irq1", {31'b0, irq}, 32'h1);
    step(1);
    chk("sim_c_irq0", {31'b0, irq}, 32'h0);

    // Wrap-around: COUNT=FFFFFFFF, COMPARE=2, one-shot.
    reset_dut();
    bus_write(A_COUNT, 32'hFFFF_FFFF);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'h1);
    rd_chk("wr_e0", A_COUNT, 32'hFFFF_FFFF);
    step(1);  rd_chk("wr_e1", A_COUNT, 32'd0);
    rd_chk("wr_e1_st", A_STATUS, 32'h2);
    step(1);  rd_chk("wr_e2", A_COUNT, 32'd1);
    step(1);  rd_chk("wr_e3", A_COUNT, 32'd2);
    rd_chk("wr_e3_st", A_STATUS, 32'h2);
    step(1);  rd_chk("wr_e4", A_COUNT, 32'd2);
    rd_chk("wr_e4_st", A_STATUS, 32'h5);

`ifdef TIMER_PWM_EN
    // PWM: COMPARE=9, DUTY=3, auto-reload -> 3 high cycles per 10.
    reset_dut();
    bus_write(A_CMP, 32'd9);
    bus_write(A_OFF5, 32'd3);
    rd_chk("pwm_duty", A_OFF5, 32'd3);
    bus_write(A_CTRL, 32'h3);
    step(1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (pwm_out) highs++;
      step(1);
    end
    chk("pwm_highs", 32'(highs), 32'd3);
    bus_write(A_OFF5, 32'd0);
    step(1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (pwm_out) highs++;
      step(1);
    end
    chk("pwm_duty0", 32'(highs), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
